// File: rtl/mips_data_memory_ctrl_if.sv
// rtl/mips_data_memory_ctrl_if.sv - request/response bus of the MIPS data memory controller
interface mips_data_memory_ctrl_if;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic [5:0]  opcode;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        ready;
  logic [31:0] read_data;
  logic        rd_valid;
  logic        err;

  modport master (
    output signal_mem_read, signal_mem_write, opcode, address, data_in,
    input  ready, read_data, rd_valid, err
  );

  modport slave (
    input  signal_mem_read, signal_mem_write, opcode, address, data_in,
    output ready, read_data, rd_valid, err
  );
endinterface

// File: rtl/mips_data_memory_ctrl.sv
// rtl/mips_data_memory_ctrl.sv - MIPS byte/half/word data memory, one-cycle load latency
// Optional macro MIPS_DMEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module mips_data_memory_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_data_memory_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [31:0] read_data_q, read_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic             is_load, is_store, sext, op_ok, oor, misalign;
  logic [1:0]       size, off;
  logic [IDX_W-1:0] idx;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word, load_val, wdata;
  logic [3:0]       be, we;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_W;
    case (bus.opcode)
      OP_LB:   begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_B; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_H; end
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      OP_SW:   begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
    op_ok = bus.signal_mem_read ? is_load : is_store;
    idx   = bus.address[IDX_W+1:2];
    oor   = |bus.address[31:IDX_W+2];
`ifdef MIPS_DMEM_MISALIGN_TRAP_EN
    misalign = ((size == SZ_H) && bus.address[0]) ||
               ((size == SZ_W) && (bus.address[1:0] != 2'b00));
    off      = bus.address[1:0];
`else
    // Low address bits below the access size are simply dropped.
    misalign = 1'b0;
    off      = (size == SZ_B) ? bus.address[1:0] :
               (size == SZ_H) ? {bus.address[1], 1'b0} : 2'b00;
`endif
    word   = mem[idx];
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_val = sext ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      SZ_H:    load_val = sext ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      default: load_val = word;
    endcase
    case (size)
      SZ_B:    begin be = 4'b0001 << off; wdata = {4{bus.data_in[7:0]}}; end
      SZ_H:    begin be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{bus.data_in[15:0]}}; end
      default: begin be = 4'b1111; wdata = bus.data_in; end
    endcase
  end

  always_comb begin
    state_d     = IDLE;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;
    read_data_d = read_data_q;
    we          = 4'b0000;
    if (state_q == IDLE && (bus.signal_mem_read || bus.signal_mem_write)) begin
      if ((bus.signal_mem_read && bus.signal_mem_write) || !op_ok) begin
        err_d = 1'b1;
      end else if (oor || misalign) begin
        // Bad-address loads still complete, returning zero alongside the error.
        err_d = 1'b1;
        if (bus.signal_mem_read) begin
          state_d     = RESP;
          rd_valid_d  = 1'b1;
          read_data_d = '0;
        end
      end else if (bus.signal_mem_read) begin
        state_d     = RESP;
        rd_valid_d  = 1'b1;
        read_data_d = load_val;
      end else begin
        we = be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.err       = err_q;
endmodule

// File: doc/mips_data_memory_ctrl.md
MIPS_DATA_MEMORY_CTRL -- requirements
Module: mips_data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter IDX_W, default 8: word-index width, equal to log2(DEPTH_WORDS).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port signal_mem_read, input, 1 bit: load request qualifier.
REQ-006 SHALL have port signal_mem_write, input, 1 bit: store request qualifier.
REQ-007 SHALL have port opcode, input, 6 bits: MIPS opcode (lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011).
REQ-008 SHALL have port address, input, 32 bits: byte address.
REQ-009 SHALL have port data_in, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port ready, output, 1 bit: a request is accepted only while high.
REQ-011 SHALL have port read_data, output, 32 bits: extended load result.
REQ-012 SHALL have port rd_valid, output, 1 bit: read_data valid this cycle.
REQ-013 SHALL have port err, output, 1 bit: one-cycle error pulse.

Function
REQ-014 SHALL have FSM states IDLE and RESP; ready = (state==IDLE).
REQ-015 SHALL accept a request at edge T when in IDLE and exactly one of signal_mem_read or signal_mem_write is high.
REQ-016 Accepted store SHALL update the array at edge T using little-endian byte lanes (address[1:0]=0 selects bits 7:0); FSM stays in IDLE, so back-to-back stores run at one per cycle.
REQ-017 sb SHALL write one byte, sh one halfword (lane address[1]), and sw the full word; other bytes are unchanged.
REQ-018 Accepted load SHALL move FSM to RESP; in cycle T+1 rd_valid=1 and read_data holds the value; FSM returns to IDLE at edge T+1.
REQ-019 lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend; lw returns the whole word.
REQ-020 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-021 Word index = address[IDX_W+1:2]; a nonzero address[31:IDX_W+2] SHALL be out-of-range: no write, load returns 0, err=1 in cycle T+1.
REQ-022 Both qualifiers high, or a qualifier with a mismatched/unsupported opcode, SHALL cause no access and err=1 in cycle T+1; FSM SHALL NOT leave IDLE.
REQ-023 Outside RESP, read_data SHALL hold its last value and rd_valid SHALL be 0; requests while ready=0 SHALL be ignored.

Reset
REQ-024 On rst_n low: state=IDLE, ready=1, read_data=0, rd_valid=0, err=0, immediately and independently of clk.
REQ-025 Reset asserted in RESP SHALL abort the response (no rd_valid pulse); array contents SHALL NOT be reset.

Configuration
REQ-026 With macro MIPS_DMEM_MISALIGN_TRAP_EN defined, misaligned access (half with address[0]=1, word with address[1:0]!=0) SHALL perform no write, return 0 for loads, and pulse err in T+1.
REQ-027 Without MIPS_DMEM_MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to zero (natural alignment), and no err is raised.

Verification
REQ-028 Reset mid-load: rst_n low during RESP -> rd_valid never pulses; ready=1, read_data=0.
REQ-029 sw 0x12345678 @0x10, then lb @0x13 -> read_data=0x00000012; lbu @0x10 -> 0x00000078; lh @0x12 -> 0x00001234.
REQ-030 sh 0xFFFFFFFF @0x2 over word 0x00000000, then lw @0x0 -> 0xFFFF0000; lh @0x2 -> 0xFFFFFFFF; lhu @0x2 -> 0x0000FFFF.
REQ-031 sh @0x1 -> with MIPS_DMEM_MISALIGN_TRAP_EN: err=1 at T+1, memory unchanged; without: lane 0 written, err=0.
REQ-032 Both qualifiers high, opcode 101011 -> err=1 at T+1, no write, ready stays 1; address 0x00000400 at DEPTH_WORDS=256 with lw -> err=1, read_data=0.
REQ-033 Store then load same word on consecutive cycles -> load returns new data with one-cycle latency; a request during RESP is ignored.
